cpu_step_ctrl: RTL and testbench
================================

// Module: cpu_step_ctrl
// PURPOSE
//   Fast-clock consumer of the divided slow clock on the board-test build.
//   Turns slow-clock rising edges (RUN) or debounced push-button presses (STEP)
//   into single-cycle cpu_en pulses that gate the single-cycle MIPS core.
//   Honours a halt request from the core and counts issued steps for display.
// PARAMETERS
//   DEB_W  20         width of the debounce counter
//   DEB_M  1_000_000  consecutive stable cycles before the debounced button changes (DEB_M <= 2^DEB_W-1)
//   CNT_W  16         width of step_count
// PORTS
//   clk          in   1      system clock; all logic on posedge
//   rst_n        in   1      asynchronous, active-low reset
//   slow_clk_in  in   1      divided clock; treated as asynchronous level
//   btn_step     in   1      raw, bouncy step push-button (1 = pressed)
//   mode_run     in   1      switch: 1 = free-run on slow clock, 0 = single-step
//   halt_req     in   1      core halt request (e.g. syscall/break), level, synchronous to clk
//   cpu_en       out  1      one-cycle clock-enable pulse to the core
//   step_count   out  CNT_W  number of cpu_en pulses issued since reset
//   state        out  2      FSM state: 00 STEP, 01 RUN, 11 HALT (10 unused)
//   halted       out  1      1 while state == HALT
// BEHAVIOUR
//   Reset (async, rst_n=0): all flops cleared immediately. cpu_en=0, step_count=0,
//     state=STEP, halted=0, sync flops=0, debounce counter=0, debounced btn=0.
//     Reset mid-pulse drops cpu_en at once; the pulse is not counted.
//   Synchronisers: slow_clk_in, btn_step and mode_run each pass through 2 flops (s1->s2).
//   Tick: prev flop holds the previous slow s2. tick = s2 & ~prev.
//     Latency: slow_clk_in first sampled high at edge k -> cpu_en high after edge k+2
//     for exactly one cycle (RUN only). A level held high yields one tick only.
//   Debounce: btn_db changes only after btn s2 != btn_db for DEB_M consecutive cycles.
//     The counter clears on any cycle where they are equal. press = one-cycle pulse
//     on the btn_db 0->1 transition; release produces nothing.
//   FSM (registered; cpu_en is registered and asserts in the cycle after its cause):
//     STEP: halt_req -> HALT (no pulse); else mode s2=1 -> RUN (no pulse);
//           else press -> cpu_en pulse, stay STEP.
//     RUN : halt_req -> HALT (no pulse); else mode s2=0 -> STEP (no pulse, tick dropped);
//           else tick -> cpu_en pulse. press is ignored.
//     HALT: cpu_en held 0. Ticks are ignored. press with halt_req=0 -> STEP
//           (press consumed, no pulse). press while halt_req=1 -> stay HALT.
//   Priority in one cycle: halt_req > mode change > tick/press.
//   step_count: +1 on every cycle cpu_en=1; wraps 2^CNT_W-1 -> 0 with no flag.
//   cpu_en never asserts in two consecutive cycles. Every path that issues cpu_en
//     requires a tick or a press, and both are single-cycle edges.
// TESTING (bench params DEB_M=4, DEB_W=3, CNT_W=4)
//   1 Reset: rst_n=0 mid-run -> same cycle cpu_en=0, step_count=0, state=00;
//     after release, state=00.
//   2 RUN: mode_run=1, slow_clk_in toggled every 10 clk -> one cpu_en per rising edge,
//     3rd edge after the input rises, step_count 0->1->2->3.
//   3 Debounce: btn_step bounce 1,0,1,1,0 then steady 1 for 6 cycles in STEP ->
//     exactly one cpu_en, 4 stable cycles + sync after the last bounce; release -> no pulse.
//   4 Halt priority: halt_req=1 on the same cycle tick fires in RUN -> no cpu_en,
//     state=11, halted=1. Later ticks -> no pulse. Press with halt_req=0 ->
//     state=00, step_count unchanged.
//   5 Wrap: 17 steps from reset -> step_count goes 15 -> 0 -> 1.
//   6 Mode switch: mode_run 1->0 with a tick in the same cycle as mode s2 falls
//     -> no pulse, state=00. Press then gives one pulse.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
//   Fast-clock consumer of the divided slow clock on the board-test build.
//   It turns rising edges of the slow clock (RUN mode) or debounced
//   step-button presses (STEP mode) into single-cycle cpu_en pulses that gate
//   the single-cycle core. It honours the core's halt request and counts the
//   pulses it issues, for display.
//
// Ports
//   clk          in   system clock; all logic is on posedge
//   rst_n        in   asynchronous, active-low reset
//   slow_clk_in  in   divided clock, treated as an asynchronous level
//   btn_step     in   raw, bouncy step push-button (1 = pressed)
//   mode_run     in   switch: 1 = free-run on the slow clock, 0 = single-step
//   halt_req     in   core halt request; a level, synchronous to clk
//   cpu_en       out  one-cycle clock-enable pulse to the core
//   step_count   out  number of cpu_en pulses issued since reset (wraps)
//   state        out  FSM state: 00 STEP, 01 RUN, 11 HALT
//   halted       out  1 while state == HALT
module cpu_step_ctrl #(
  parameter int DEB_W = 20,
  parameter int DEB_M = 1_000_000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk_in,
  input  logic             btn_step,
  input  logic             mode_run,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       state,
  output logic             halted
);

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b11
  } state_e;

  // Last count value before btn_db is allowed to follow btn_s2.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_M - 1);

  state_e           st;
  logic             slow_s1, slow_s2, slow_prev;
  logic             btn_s1, btn_s2;
  logic             mode_s1, mode_s2;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_db;
  logic             press;
  logic             tick;

  // Two-flop synchronisers for the three asynchronous inputs, plus the
  // previous-value flop for slow-clock edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_s1   <= 1'b0;
      slow_s2   <= 1'b0;
      slow_prev <= 1'b0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      mode_s1   <= 1'b0;
      mode_s2   <= 1'b0;
    end else begin
      slow_s1   <= slow_clk_in;
      slow_s2   <= slow_s1;
      slow_prev <= slow_s2;
      btn_s1    <= btn_step;
      btn_s2    <= btn_s1;
      mode_s1   <= mode_run;
      mode_s2   <= mode_s1;
    end
  end

  // A level held high produces a single tick, since prev catches up one
  // cycle later.
  assign tick = slow_s2 & ~slow_prev;

  // Debounce: btn_db follows btn_s2 only after DEB_M consecutive cycles of
  // disagreement. Any agreeing cycle restarts the count. press is registered
  // and is high for the single cycle after btn_db goes 0->1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      btn_db  <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        btn_db  <= btn_s2;
        press   <= btn_s2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Control FSM. Within a cycle, halt_req wins over a mode change, and a
  // mode change wins over tick/press. A mode change drops a coincident tick.
  // cpu_en is high only for one cycle after a tick or press, so it cannot
  // assert in two consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_STEP;
      cpu_en <= 1'b0;
    end else begin
      cpu_en <= 1'b0;
      unique case (st)
        ST_STEP: begin
          if (halt_req)     st     <= ST_HALT;
          else if (mode_s2) st     <= ST_RUN;
          else if (press)   cpu_en <= 1'b1;
        end
        ST_RUN: begin
          if (halt_req)      st     <= ST_HALT;
          else if (!mode_s2) st     <= ST_STEP;
          else if (tick)     cpu_en <= 1'b1;
        end
        ST_HALT: begin
          // A press leaves HALT but is consumed without a pulse.
          if (press && !halt_req) st <= ST_STEP;
        end
        default: st <= ST_STEP;
      endcase
    end
  end

  // Counts pulses actually delivered. A pulse cut short by reset is never
  // counted, because reset clears both registers together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      step_count <= '0;
    else if (cpu_en) step_count <= step_count + 1'b1;
  end

  assign state  = st;
  assign halted = (st == ST_HALT);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;
  localparam int DEB_W = 3;
  localparam int DEB_M = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             slow_clk_in, btn_step, mode_run, halt_req;
  logic             cpu_en;
  logic [CNT_W-1:0] step_count;
  logic [1:0]       state;
  logic             halted;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;
  logic last_en = 1'b0;
  int p0;

  cpu_step_ctrl #(.DEB_W(DEB_W), .DEB_M(DEB_M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk_in(slow_clk_in), .btn_step(btn_step),
    .mode_run(mode_run), .halt_req(halt_req), .cpu_en(cpu_en),
    .step_count(step_count), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts delivered pulses and flags back-to-back ones.
  always @(negedge clk) begin
    if (cpu_en) begin
      n_pulse++;
      chk("no_back_to_back", {31'd0, last_en}, 32'd0);
    end
    last_en <= cpu_en;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; slow_clk_in = 1'b0; btn_step = 1'b0; mode_run = 1'b0; halt_req = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Steady press long enough to debounce, then release and wait out the release.
  task automatic press_btn();
    btn_step = 1'b1;
    step(6);
    btn_step = 1'b0;
    step(14);
  endtask

  // One slow-clock period in RUN: rising edge -> pulse after the 3rd clk edge.
  task automatic run_edge(input int n);
    slow_clk_in = 1'b1;
    step(); chk("run_en_k",  {31'd0, cpu_en}, 32'd0);
    step(); chk("run_en_k1", {31'd0, cpu_en}, 32'd0);
    step(); chk("run_en_k2", {31'd0, cpu_en}, 32'd1);
    chk("run_cnt_pre", step_count, n - 1);
    step(); chk("run_en_k3", {31'd0, cpu_en}, 32'd0);
    chk("run_cnt", step_count, n);
    step(6);
    slow_clk_in = 1'b0;
    step(10);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_cnt", step_count, 32'd0);
    chk("rst_state", state, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // RUN: three slow-clock rising edges
    mode_run = 1'b1;
    step(4);
    chk("run_state", state, 32'd1);
    p0 = n_pulse;
    for (int e = 1; e <= 3; e++) run_edge(e);
    chk("run_pulses", n_pulse - p0, 32'd3);

    // Reset mid-pulse
    slow_clk_in = 1'b1;
    step(3);
    chk("mid_en_before", {31'd0, cpu_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {31'd0, cpu_en}, 32'd0);
    chk("mid_rst_cnt", step_count, 32'd0);
    chk("mid_rst_state", state, 32'd0);
    slow_clk_in = 1'b0; mode_run = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_state", state, 32'd0);
    step(3);
    chk("post_rst_state2", state, 32'd0);
    chk("post_rst_cnt", step_count, 32'd0);

    // Debounce in STEP: bounce, then steady press, then release
    p0 = n_pulse;
    btn_step = 1'b1; step();
    btn_step = 1'b0; step();
    btn_step = 1'b1; step();
    btn_step = 1'b1; step();
    btn_step = 1'b0; step();
    chk("deb_bounce_pulses", n_pulse - p0, 32'd0);
    btn_step = 1'b1;
    step(6);
    chk("deb_en_early", {31'd0, cpu_en}, 32'd0);
    btn_step = 1'b0;
    step();
    chk("deb_en", {31'd0, cpu_en}, 32'd1);
    step();
    chk("deb_cnt", step_count, 32'd1);
    chk("deb_state", state, 32'd0);
    step(20);
    chk("deb_pulses", n_pulse - p0, 32'd1);

    // Halt wins over a coincident tick in RUN
    mode_run = 1'b1;
    step(4);
    chk("halt_pre_state", state, 32'd1);
    p0 = n_pulse;
    slow_clk_in = 1'b1;
    step(2);
    halt_req = 1'b1;
    step();
    chk("halt_en", {31'd0, cpu_en}, 32'd0);
    chk("halt_state", state, 32'd3);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    step(7);
    slow_clk_in = 1'b0;
    // Press while halt_req is still high keeps HALT
    btn_step = 1'b1;
    step(6);
    btn_step = 1'b0;
    step();
    chk("halt_press_held", state, 32'd3);
    step(14);
    halt_req = 1'b0;
    // Ticks in HALT are ignored
    slow_clk_in = 1'b1; step(10);
    slow_clk_in = 1'b0; step(10);
    slow_clk_in = 1'b1; step(10);
    slow_clk_in = 1'b0; step(10);
    chk("halt_tick_state", state, 32'd3);
    mode_run = 1'b0;
    step(3);
    // Press with halt_req low leaves HALT without a pulse
    btn_step = 1'b1;
    step(6);
    chk("halt_exit_early", state, 32'd3);
    btn_step = 1'b0;
    step();
    chk("halt_exit_state", state, 32'd0);
    chk("halt_exit_halted", {31'd0, halted}, 32'd0);
    step(14);
    chk("halt_exit_cnt", step_count, 32'd1);
    chk("halt_pulses", n_pulse - p0, 32'd0);

    // Wrap: 17 steps from reset
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      press_btn();
      if (i == 15) chk("wrap_15", step_count, 32'd15);
      if (i == 16) chk("wrap_16", step_count, 32'd0);
      if (i == 17) chk("wrap_17", step_count, 32'd1);
    end

    // Mode switch with a tick in the same cycle mode falls
    mode_run = 1'b1;
    step(4);
    chk("msw_run", state, 32'd1);
    p0 = n_pulse;
    mode_run = 1'b0;
    slow_clk_in = 1'b1;
    step(3);
    chk("msw_en", {31'd0, cpu_en}, 32'd0);
    chk("msw_state", state, 32'd0);
    step(6);
    slow_clk_in = 1'b0;
    step(5);
    chk("msw_no_pulse", n_pulse - p0, 32'd0);
    press_btn();
    chk("msw_press_pulse", n_pulse - p0, 32'd1);
    chk("msw_cnt", step_count, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
